// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the ID-stage hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int REG_ZERO = 0;

  // Stall lengths per hazard class (cycles the ID instruction must wait)
  localparam int STALL_LOAD_USE    = 1;
  localparam int STALL_BR_ALU      = 1;
  localparam int STALL_BR_LOAD     = 2;
  localparam int STALL_BR_LOAD_MEM = 1;

endpackage

// File: rtl/hazard_need_calc.sv
// Combinational hazard classification: register matches against EX and EX/MEM
// and the number of stall cycles the ID instruction needs.
module hazard_need_calc
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2
) (
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  uses_rt_id,
  input  logic                  is_branch_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  reg_write_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex_m,
  input  logic                  reg_write_ex_m,
  input  logic                  mem_read_ex_m,
  output logic [CNT_W-1:0]      need,
  output logic                  match_a_ex_m,
  output logic                  match_b_ex_m
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

  logic match_a_ex, match_b_ex, match_ex, match_ex_m;

  assign match_a_ex   = (rd_ex != ZERO) && (rd_ex == rs_id);
  assign match_b_ex   = (rd_ex != ZERO) && (rd_ex == rt_id) && uses_rt_id;
  assign match_a_ex_m = (rd_ex_m != ZERO) && (rd_ex_m == rs_id);
  assign match_b_ex_m = (rd_ex_m != ZERO) && (rd_ex_m == rt_id) && uses_rt_id;
  assign match_ex     = match_a_ex || match_b_ex;
  assign match_ex_m   = match_a_ex_m || match_b_ex_m;

  // A load in EX feeding the comparator dominates any EX/MEM condition
  always_comb begin
    need = '0;
    if (is_branch_id && mem_read_ex && match_ex)
      need = CNT_W'(STALL_BR_LOAD);
    else if (!is_branch_id && mem_read_ex && match_ex)
      need = CNT_W'(STALL_LOAD_USE);
    else if (is_branch_id && reg_write_ex && !mem_read_ex && match_ex)
      need = CNT_W'(STALL_BR_ALU);
    else if (is_branch_id && mem_read_ex_m && match_ex_m)
      need = CNT_W'(STALL_BR_LOAD_MEM);
  end

endmodule

// File: rtl/id_hazard_controller.sv
// ID-stage hazard sequencing: stall FSM, flush/bypass decode.
// Optional stall cycle counter enabled by HAZARD_PERF_COUNTER_EN.
module id_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_STALL  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  uses_rt_id,
  input  logic                  is_branch_id,
  input  logic                  branch_taken_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  reg_write_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex_m,
  input  logic                  reg_write_ex_m,
  input  logic                  mem_read_ex_m,
  input  logic                  ext_hold,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  forward_a_id,
  output logic                  forward_b_id,
  output logic                  stall_active
`ifdef HAZARD_PERF_COUNTER_EN
  ,
  input  logic                  stall_cycles_clr,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] need;
  logic             match_a_ex_m, match_b_ex_m;
  logic             stall_req;

  hazard_need_calc #(
    .REG_ADDR_W(REG_ADDR_W),
    .CNT_W     (CNT_W)
  ) u_need (
    .rs_id         (rs_id),
    .rt_id         (rt_id),
    .uses_rt_id    (uses_rt_id),
    .is_branch_id  (is_branch_id),
    .rd_ex         (rd_ex),
    .reg_write_ex  (reg_write_ex),
    .mem_read_ex   (mem_read_ex),
    .rd_ex_m       (rd_ex_m),
    .reg_write_ex_m(reg_write_ex_m),
    .mem_read_ex_m (mem_read_ex_m),
    .need          (need),
    .match_a_ex_m  (match_a_ex_m),
    .match_b_ex_m  (match_b_ex_m)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // In STALL the committed length runs out regardless of the current `need`
  assign stall_req = (state == ST_STALL) || (need != '0);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    forward_a_id = 1'b0;
    forward_b_id = 1'b0;
    stall_active = (state == ST_STALL);

    if (!ext_hold) begin
      case (state)
        ST_RUN: if (need > CNT_W'(1)) begin
          state_n = ST_STALL;
          cnt_n   = need - CNT_W'(1);
        end
        ST_STALL: if (cnt <= CNT_W'(1)) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
        default: state_n = ST_RUN;
      endcase
    end

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_active = 1'b0;
    end else if (ext_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (stall_req) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush = is_branch_id && branch_taken_id;
    end

    if (!reset && !stall_req) begin
      forward_a_id = reg_write_ex_m && !mem_read_ex_m && match_a_ex_m;
      forward_b_id = reg_write_ex_m && !mem_read_ex_m && match_b_ex_m;
    end
  end

`ifdef HAZARD_PERF_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_cycles_clr)
      stall_cycles <= '0;
    else if (id_ex_bubble && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Self-checking bench for id_hazard_controller: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_id_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rd_ex, rd_ex_m;
  logic       uses_rt_id, is_branch_id, branch_taken_id;
  logic       reg_write_ex, mem_read_ex, reg_write_ex_m, mem_read_ex_m, ext_hold;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic       forward_a_id, forward_b_id, stall_active;
`ifdef HAZARD_PERF_COUNTER_EN
  logic        stall_cycles_clr;
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stall_active}
  logic [6:0] outs;
  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                 forward_a_id, forward_b_id, stall_active};

  localparam logic [6:0] O_IDLE  = 7'b1100000;
  localparam logic [6:0] O_RST   = 7'b0001000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_STL2  = 7'b0001001;
  localparam logic [6:0] O_HOLDS = 7'b0000001;

  id_hazard_controller #(.REG_ADDR_W(5), .MAX_STALL(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .rs_id          (rs_id),
    .rt_id          (rt_id),
    .uses_rt_id     (uses_rt_id),
    .is_branch_id   (is_branch_id),
    .branch_taken_id(branch_taken_id),
    .rd_ex          (rd_ex),
    .reg_write_ex   (reg_write_ex),
    .mem_read_ex    (mem_read_ex),
    .rd_ex_m        (rd_ex_m),
    .reg_write_ex_m (reg_write_ex_m),
    .mem_read_ex_m  (mem_read_ex_m),
    .ext_hold       (ext_hold),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .forward_a_id   (forward_a_id),
    .forward_b_id   (forward_b_id),
    .stall_active   (stall_active)
`ifdef HAZARD_PERF_COUNTER_EN
    ,
    .stall_cycles_clr(stall_cycles_clr),
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic tk,
                       input logic [4:0] rdx, input logic rwx, input logic mrx,
                       input logic [4:0] rdm, input logic rwm, input logic mrm,
                       input logic hold);
    rs_id = rs; rt_id = rt; uses_rt_id = urt; is_branch_id = br; branch_taken_id = tk;
    rd_ex = rdx; reg_write_ex = rwx; mem_read_ex = mrx;
    rd_ex_m = rdm; reg_write_ex_m = rwm; mem_read_ex_m = mrm; ext_hold = hold;
    #1;
  endtask

  task automatic idle_in();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Stall cycles required, straight from the hazard table
  function automatic int model_need(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                                    input logic br, input logic [4:0] rdx, input logic rwx,
                                    input logic mrx, input logic [4:0] rdm, input logic rwm,
                                    input logic mrm);
    bit hx = (rdx != 0) && ((rdx == rs) || (urt && rdx == rt));
    bit hm = (rdm != 0) && ((rdm == rs) || (urt && rdm == rt));
    if (br && mrx && hx) return 2;
    if (!br && mrx && hx) return 1;
    if (br && rwx && !mrx && hx) return 1;
    if (br && mrm && hm) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    checks++;
    if (outs !== O_RST) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", outs, O_RST);
    end
    tick();
    reset = 1'b0;
    idle_in();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL idle_after_reset got=%b want=%b", outs, O_IDLE);
    end
`ifdef HAZARD_PERF_COUNTER_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL perf_reset got=%0d want=0", stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    apply(5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL load_use_stall got=%b want=%b", outs, O_STALL);
    end
    tick();
    idle_in();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL load_use_release got=%b want=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_branch_load();
    apply(5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL br_load_cycle1 got=%b want=%b", outs, O_STALL);
    end
    tick();
    checks++;
    if (outs !== O_STL2) begin
      errors++; $display("FAIL br_load_cycle2 got=%b want=%b", outs, O_STL2);
    end
    tick();
    apply(5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL br_load_resolve got=%b want=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_branch_fwd_flush();
    apply(5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== 7'b1110010) begin
      errors++; $display("FAIL fwd_b_flush got=%b want=%b", outs, 7'b1110010);
    end
    tick();
    idle_in();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL flush_single got=%b want=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_reg_zero();
    apply(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reg_zero got=%b want=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_hold_in_stall();
    apply(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL hold_enter got=%b want=%b", outs, O_STALL);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs !== O_HOLDS) begin
        errors++; $display("FAIL hold_frozen[%0d] got=%b want=%b", i, outs, O_HOLDS);
      end
      tick();
    end
    // Hazard gone, but the committed stall cycle must still happen
    apply(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_STL2) begin
      errors++; $display("FAIL hold_last_stall got=%b want=%b", outs, O_STL2);
    end
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL hold_release got=%b want=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply(5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (outs !== O_STL2) begin
      errors++; $display("FAIL midrst_in_stall got=%b want=%b", outs, O_STL2);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_RST) begin
      errors++; $display("FAIL midrst_async got=%b want=%b", outs, O_RST);
    end
    tick();
    reset = 1'b0;
    idle_in();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL midrst_idle got=%b want=%b", outs, O_IDLE);
    end
`ifdef HAZARD_PERF_COUNTER_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL midrst_perf got=%0d want=0", stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    int left = 0;
    longint perf = 0;
    int nd;
    bit in_stall, stl, rst_now, clr_now, fa, fb, fl, bub;
    logic [6:0] exp;
    for (int n = 0; n < 600; n++) begin
      rst_now = ($urandom_range(0, 39) == 0);
      clr_now = ($urandom_range(0, 19) == 0);
      reset = rst_now;
`ifdef HAZARD_PERF_COUNTER_EN
      stall_cycles_clr = clr_now;
`endif
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0));
      if (rst_now) begin
        exp = O_RST;
        bub = 1'b1;
      end else begin
        in_stall = (left > 0);
        nd = model_need(rs_id, rt_id, uses_rt_id, is_branch_id, rd_ex, reg_write_ex,
                        mem_read_ex, rd_ex_m, reg_write_ex_m, mem_read_ex_m);
        stl = in_stall || (nd > 0);
        bub = !ext_hold && stl;
        fl  = !ext_hold && !stl && is_branch_id && branch_taken_id;
        fa  = !stl && reg_write_ex_m && !mem_read_ex_m && (rd_ex_m != 0) && (rd_ex_m == rs_id);
        fb  = !stl && reg_write_ex_m && !mem_read_ex_m && (rd_ex_m != 0) &&
              uses_rt_id && (rd_ex_m == rt_id);
        exp = {!ext_hold && !stl, !ext_hold && !stl, fl, bub, fa, fb, in_stall};
      end
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL random[%0d] got=%b want=%b", n, outs, exp);
      end
`ifdef HAZARD_PERF_COUNTER_EN
      checks++;
      if (stall_cycles !== 32'(perf)) begin
        errors++; $display("FAIL random_perf[%0d] got=%0d want=%0d", n, stall_cycles, perf);
      end
`endif
      // advance the model across the clock edge
      if (rst_now) begin
        left = 0;
        perf = 0;
      end else begin
        if (!ext_hold) begin
          if (left > 0) left = left - 1;
          else if (nd > 0) left = nd - 1;
        end
        if (clr_now) perf = 0;
        else if (bub && perf < 64'hFFFF_FFFF) perf = perf + 1;
      end
      tick();
    end
    reset = 1'b0;
`ifdef HAZARD_PERF_COUNTER_EN
    stall_cycles_clr = 1'b0;
`endif
  endtask

  initial begin
`ifdef HAZARD_PERF_COUNTER_EN
    stall_cycles_clr = 1'b0;
`endif
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_fwd_flush();
    test_reg_zero();
    test_hold_in_stall();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_controller.md
Name: id_hazard_controller

Overview:
- Sequences the pipeline around the ID-stage branch comparator and operand bypass.
- Detects load-use and branch-operand hazards against the EX and EX/MEM stages.
- Holds PC and IF/ID for the required number of cycles, injects ID/EX bubbles, and generates the IF/ID flush for taken branches.
- Drives the ID bypass selects, so ID forwarding and stalling are decided in one place.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- MAX_STALL, 2, maximum consecutive hazard stall cycles; stall counter width is clog2(MAX_STALL+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rs_id  in  REG_ADDR_W  ID source register 1
- rt_id  in  REG_ADDR_W  ID source register 2
- uses_rt_id  in  1  ID instruction reads rt
- is_branch_id  in  1  ID instruction is BEQ/BNE (compares in ID)
- branch_taken_id  in  1  ID comparator result, valid when is_branch_id
- rd_ex  in  REG_ADDR_W  destination register in EX
- reg_write_ex  in  1  EX writes the register file
- mem_read_ex  in  1  EX is a load
- rd_ex_m  in  REG_ADDR_W  destination register in EX/MEM
- reg_write_ex_m  in  1  EX/MEM writes the register file
- mem_read_ex_m  in  1  EX/MEM is a load
- ext_hold  in  1  external freeze request (debug/memory wait)
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  clear IF/ID (taken branch)
- id_ex_bubble  out  1  force ID/EX control to zero
- forward_a_id  out  1  bypass EX/MEM result to comparator A
- forward_b_id  out  1  bypass EX/MEM result to comparator B
- stall_active  out  1  FSM in STALL state

Behaviour:
- Match rule: mX_ex = (rd_ex != 0) && (rd_ex == rX_id); rt matches are qualified by uses_rt_id. The same rule applies for EX/MEM using rd_ex_m.
- Required stall count `need`, computed combinationally:
  - 2: is_branch_id && mem_read_ex && match_ex
  - 1: !is_branch_id && mem_read_ex && match_ex (load-use)
  - 1: is_branch_id && reg_write_ex && !mem_read_ex && match_ex
  - 1: is_branch_id && mem_read_ex_m && match_ex_m
  - 0: otherwise
- FSM states RUN and STALL, plus a cnt register.
  - RUN, need>0, !ext_hold: stall outputs asserted this cycle. If need>1, go to STALL with cnt=need-1; else stay in RUN.
  - STALL: stall outputs asserted. cnt decrements each non-held cycle. When cnt reaches 1, return to RUN on the next edge.
  - Once in STALL, the stall length is committed; `need` is not re-evaluated until back in RUN.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- ext_hold has highest priority:
  - pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - FSM state and cnt are frozen; any hazard is re-evaluated after release.
- Flush: if_id_flush=1 only in RUN, need==0, !ext_hold, is_branch_id && branch_taken_id. Single cycle, pc_write=1.
- forward_a_id = reg_write_ex_m && !mem_read_ex_m && match_a_ex_m. forward_b_id uses the same rule with rt.
  - Forwards are forced to 0 while in STALL or on a cycle where need>0.
- Reset, asynchronous and also mid-stall:
  - state=RUN, cnt=0.
  - While reset is high: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, forwards=0, stall_active=0.
- Register 0 never causes a hazard or a forward.
- Idle outputs: pc_write=1, if_id_write=1, all others 0.

Optional Feature:
- Macro HAZARD_PERF_COUNTER_EN.
- Defined: adds output stall_cycles (32 bits) and input stall_cycles_clr.
  - The counter increments on every cycle with id_ex_bubble=1 outside reset, and saturates at all-ones.
  - clr has priority over increment.
  - Reset value is 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (ST_RUN=1'b0, ST_STALL=1'b1)
  - REG_ZERO constant
  - stall-count constants (STALL_LOAD_USE=1, STALL_BR_ALU=1, STALL_BR_LOAD=2, STALL_BR_LOAD_MEM=1)
- One natural sub-module: hazard_need_calc, the purely combinational computation of `need` and the match signals. The top holds the FSM, counter, output decode and optional perf counter.

Test Plan:
- LW $2 in EX (rd_ex=2, mem_read_ex=1); ADD in ID with rs_id=2 -> one cycle pc_write=0, id_ex_bubble=1, stall_active=0; next cycle outputs idle.
- LW $3 in EX; BEQ in ID rs=3 -> two stall cycles, stall_active=1 on the second; then forward_a_id=0 and the branch resolves with no further stall.
- ADD $4 in EX/MEM (reg_write_ex_m=1); BEQ rt=4, uses_rt_id=1, taken=1 -> forward_b_id=1, if_id_flush=1 for one cycle, pc_write=1.
- rd_ex=0 with mem_read_ex=1, rs_id=0 -> no stall, forwards 0.
- Enter STALL (cnt=1), assert ext_hold for 3 cycles -> id_ex_bubble=0, state frozen; after release exactly one more stall cycle.
- Assert reset during STALL -> immediately pc_write=0, stall_active=0. After deassert, idle outputs; with HAZARD_PERF_COUNTER_EN, stall_cycles=0.
